// File: rtl/synapse_integrator.sv
// Per-input axonal delay lines feeding a leaky, saturating Q16.16 current
// register that drives one downstream neuron's input current.
module synapse_integrator #(
  parameter int N_INPUTS  = 4,
  parameter int DELAY_MAX = 8,
  parameter int TAU_SHIFT = 3,
  localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  localparam int DW = $clog2(DELAY_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] spike_in,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic signed [31:0]  cfg_weight,
  input  logic [DW-1:0]       cfg_delay,
  output logic signed [31:0]  I_out,
  output logic                arrived_out
);

  localparam int SW = 32 + $clog2(N_INPUTS) + 2;
  localparam logic [DW-1:0] DMAX = DW'(DELAY_MAX);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-31){1'b1}}, {31{1'b0}}};

  logic signed [31:0]   weight [N_INPUTS];
  logic [DW-1:0]        delay  [N_INPUTS];
  logic [DELAY_MAX-1:0] dl     [N_INPUTS];

  logic [N_INPUTS-1:0]  arr;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] i_ext;
  logic signed [SW-1:0] decay;
  logic signed [SW-1:0] i_next;
  logic signed [31:0]   i_sat;
  logic [DW-1:0]        delay_wr;
  logic [31:0]          addr_ext;

  assign addr_ext = 32'(cfg_addr);
  assign delay_wr = (cfg_delay > DMAX) ? DMAX : cfg_delay;

  // Tap selection by comparison keeps the index width independent of DW.
  always_comb begin
    arr = '0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (delay[k] == '0) begin
        arr[k] = spike_in[k];
      end else begin
        for (int unsigned j = 0; j < DELAY_MAX; j++) begin
          if (delay[k] == DW'(j + 1)) arr[k] = dl[k][j];
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (arr[k]) sum = sum + {{(SW-32){weight[k][31]}}, weight[k]};
    end
    i_ext  = {{(SW-32){I_out[31]}}, I_out};
    decay  = i_ext >>> TAU_SHIFT;
    i_next = i_ext - decay + sum;
    if (i_next > SAT_MAX) begin
      i_sat = 32'sh7FFFFFFF;
    end else if (i_next < SAT_MIN) begin
      i_sat = 32'sh80000000;
    end else begin
      i_sat = i_next[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < N_INPUTS; k++) begin
        weight[k] <= '0;
        delay[k]  <= '0;
        dl[k]     <= '0;
      end
      I_out       <= '0;
      arrived_out <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_INPUTS; k++) begin
        dl[k][0] <= spike_in[k];
        for (int unsigned j = 1; j < DELAY_MAX; j++) begin
          dl[k][j] <= dl[k][j-1];
        end
        // Out-of-range addresses match no slot and are dropped.
        if (cfg_we && (addr_ext == k)) begin
          weight[k] <= cfg_weight;
          delay[k]  <= delay_wr;
        end
      end
      I_out       <= i_sat;
      arrived_out <= |arr;
    end
  end

endmodule

// File: tb/tb_synapse_integrator.sv
// Directed bench for synapse_integrator: latency, decay, delay, saturation,
// cancellation, asynchronous reset and configuration corner cases.
module tb_synapse_integrator;

  logic               clk;
  logic               reset;
  logic [3:0]         spike_in;
  logic [2:0]         spike3;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic signed [31:0] cfg_weight;
  logic [3:0]         cfg_delay;
  logic signed [31:0] I_out;
  logic               arrived_out;
  logic signed [31:0] I3;
  logic               arrived3;

  int total = 0;
  int bad   = 0;

  synapse_integrator u_dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_weight(cfg_weight), .cfg_delay(cfg_delay),
    .I_out(I_out), .arrived_out(arrived_out)
  );

  // Three-input instance so that address N_INPUTS is representable.
  synapse_integrator #(.N_INPUTS(3)) u_dut3 (
    .clk(clk), .reset(reset), .spike_in(spike3), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_weight(cfg_weight), .cfg_delay(cfg_delay),
    .I_out(I3), .arrived_out(arrived3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0; spike_in = '0; spike3 = '0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg(input int addr, input logic [31:0] w, input int d);
    logic [31:0] a;
    logic [31:0] dd;
    a = addr; dd = d;
    cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_weight = w; cfg_delay = dd[3:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (I_out !== 32'sd0 || arrived_out !== 1'b0) begin
      bad++; $display("FAIL reset: I_out=%0d arrived=%b expected 0/0", I_out, arrived_out);
    end
    total++;
    if (I3 !== 32'sd0 || arrived3 !== 1'b0) begin
      bad++; $display("FAIL reset_dut3: I_out=%0d arrived=%b expected 0/0", I3, arrived3);
    end
  endtask

  task automatic test_decay_latency();
    do_reset();
    cfg(0, 32'd65536, 0);
    spike_in = 4'b0001;
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== 32'sd65536 || arrived_out !== 1'b1) begin
      bad++; $display("FAIL decay_n1: I_out=%0d arrived=%b expected 65536/1", I_out, arrived_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd57344 || arrived_out !== 1'b0) begin
      bad++; $display("FAIL decay_n2: I_out=%0d arrived=%b expected 57344/0", I_out, arrived_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd50176 || arrived_out !== 1'b0) begin
      bad++; $display("FAIL decay_n3: I_out=%0d arrived=%b expected 50176/0", I_out, arrived_out);
    end
  endtask

  task automatic test_decay_floor();
    do_reset();
    cfg(0, 32'hFFFFFFFF, 0);
    spike_in = 4'b0001;
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== -32'sd1) begin
      bad++; $display("FAIL neg_one: I_out=%0d expected -1", I_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd0) begin
      bad++; $display("FAIL neg_one_decay: I_out=%0d expected 0", I_out);
    end
    cfg(0, 32'd7, 0);
    spike_in = 4'b0001;
    @(negedge clk); spike_in = '0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (I_out !== 32'sd7) begin
        bad++; $display("FAIL residue step %0d: I_out=%0d expected 7", i, I_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_axonal_delay();
    do_reset();
    cfg(1, 32'd131072, 3);
    spike_in = 4'b0010;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) spike_in = '0;
      total++;
      if (I_out !== 32'sd0 || arrived_out !== 1'b0) begin
        bad++; $display("FAIL delay_n%0d: I_out=%0d arrived=%b expected 0/0", i, I_out, arrived_out);
      end
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd131072 || arrived_out !== 1'b1) begin
      bad++; $display("FAIL delay_n4: I_out=%0d arrived=%b expected 131072/1", I_out, arrived_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd114688 || arrived_out !== 1'b0) begin
      bad++; $display("FAIL delay_n5: I_out=%0d arrived=%b expected 114688/0", I_out, arrived_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 4; k++) cfg(k, 32'h7FFF0000, 0);
    spike_in = 4'b1111;
    @(negedge clk);
    total++;
    if (I_out !== 32'sh7FFFFFFF) begin
      bad++; $display("FAIL sat_pos1: I_out=%h expected 7fffffff", I_out);
    end
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== 32'sh7FFFFFFF) begin
      bad++; $display("FAIL sat_pos2: I_out=%h expected 7fffffff", I_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sh70000000) begin
      bad++; $display("FAIL sat_pos_decay: I_out=%h expected 70000000", I_out);
    end

    do_reset();
    for (int k = 0; k < 4; k++) cfg(k, 32'h80010000, 0);
    spike_in = 4'b1111;
    @(negedge clk);
    total++;
    if (I_out !== 32'sh80000000) begin
      bad++; $display("FAIL sat_neg1: I_out=%h expected 80000000", I_out);
    end
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== 32'sh80000000) begin
      bad++; $display("FAIL sat_neg2: I_out=%h expected 80000000", I_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sh90000000) begin
      bad++; $display("FAIL sat_neg_decay: I_out=%h expected 90000000", I_out);
    end
  endtask

  task automatic test_cancellation();
    do_reset();
    cfg(0, 32'd65536, 0);
    cfg(1, 32'hFFFF0000, 0);
    spike_in = 4'b0011;
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== 32'sd0 || arrived_out !== 1'b1) begin
      bad++; $display("FAIL cancel: I_out=%0d arrived=%b expected 0/1", I_out, arrived_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd0 || arrived_out !== 1'b0) begin
      bad++; $display("FAIL cancel_after: I_out=%0d arrived=%b expected 0/0", I_out, arrived_out);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cfg(0, 32'd65536, 0);
    cfg(2, 32'd65536, 5);
    spike_in = 4'b0101;
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== 32'sd65536) begin
      bad++; $display("FAIL mid_n1: I_out=%0d expected 65536", I_out);
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd57344) begin
      bad++; $display("FAIL mid_n2: I_out=%0d expected 57344", I_out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (I_out !== 32'sd0 || arrived_out !== 1'b0) begin
      bad++; $display("FAIL mid_async: I_out=%0d arrived=%b expected 0/0", I_out, arrived_out);
    end
    @(negedge clk); reset = 1'b1;
    for (int i = 4; i <= 10; i++) begin
      @(negedge clk);
      total++;
      if (I_out !== 32'sd0 || arrived_out !== 1'b0) begin
        bad++; $display("FAIL mid_n%0d: I_out=%0d arrived=%b expected 0/0", i, I_out, arrived_out);
      end
    end
    spike_in = 4'b0101;
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== 32'sd0 || arrived_out !== 1'b1) begin
      bad++; $display("FAIL mid_weights: I_out=%0d arrived=%b expected 0/1", I_out, arrived_out);
    end
  endtask

  task automatic test_config_edges();
    do_reset();
    cfg(3, 32'd65536, 0);
    cfg(2, 32'd131072, 0);
    spike3 = 3'b111;
    @(negedge clk); spike3 = '0;
    total++;
    if (I3 !== 32'sd131072 || arrived3 !== 1'b1) begin
      bad++; $display("FAIL cfg_oob: I_out=%0d arrived=%b expected 131072/1", I3, arrived3);
    end

    do_reset();
    cfg(0, 32'd65536, 15);
    spike_in = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) spike_in = '0;
      total++;
      if (I_out !== 32'sd0 || arrived_out !== 1'b0) begin
        bad++; $display("FAIL clamp_n%0d: I_out=%0d arrived=%b expected 0/0", i, I_out, arrived_out);
      end
    end
    @(negedge clk);
    total++;
    if (I_out !== 32'sd65536 || arrived_out !== 1'b1) begin
      bad++; $display("FAIL clamp_n9: I_out=%0d arrived=%b expected 65536/1", I_out, arrived_out);
    end

    do_reset();
    cfg(0, 32'd65536, 0);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_weight = 32'sd196608; cfg_delay = 4'd0;
    spike_in = 4'b0001;
    @(negedge clk); cfg_we = 1'b0;
    total++;
    if (I_out !== 32'sd65536) begin
      bad++; $display("FAIL cfg_old_weight: I_out=%0d expected 65536", I_out);
    end
    @(negedge clk); spike_in = '0;
    total++;
    if (I_out !== 32'sd253952) begin
      bad++; $display("FAIL cfg_new_weight: I_out=%0d expected 253952", I_out);
    end
  endtask

  initial begin
    reset = 1'b0; spike_in = '0; spike3 = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_weight = '0; cfg_delay = '0;
    test_reset();
    test_decay_latency();
    test_decay_floor();
    test_axonal_delay();
    test_saturation();
    test_cancellation();
    test_reset_midflight();
    test_config_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
